// File: rtl/harvard_mem_sequencer.sv
// Runs a Harvard-style CPU from one single-ported unified memory: instruction fetch, then an optional data access, then one clock_enable pulse.
// Define HARVARD_SEQ_PERF_EN to add the perf_cycles / perf_retired / perf_stall counter outputs.
module harvard_mem_sequencer #(
    parameter int WAIT_LIMIT = 255,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       cpu_instr_address,
    output logic [31:0]       cpu_instr_readdata,
    input  logic [31:0]       cpu_data_address,
    input  logic              cpu_data_read,
    input  logic              cpu_data_write,
    input  logic [31:0]       cpu_data_writedata,
    output logic [31:0]       cpu_data_readdata,
    input  logic              cpu_active,
    output logic              cpu_clock_enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic              mem_waitrequest,
    input  logic [31:0]       mem_readdata,
    output logic              bus_error,
    output logic [2:0]        dbg_state
`ifdef HARVARD_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_retired,
    output logic [31:0]       perf_stall
`endif
);

    localparam int CNT_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WAIT_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FETCH      = 3'd1,
        S_FETCH_WAIT = 3'd2,
        S_DATA       = 3'd3,
        S_DATA_WAIT  = 3'd4,
        S_EXEC       = 3'd5,
        S_HALTED     = 3'd6
    } state_e;

    state_e           state_q, state_d;
    state_e           accept_state;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      data_q, data_d;
    logic             bus_error_q, bus_error_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] wait_inc;

    assign wait_inc = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;

    // Memory outputs are decoded from state so an asynchronous reset clears them at once.
    always_comb begin
        state_d          = state_q;
        accept_state     = state_q;
        instr_d          = instr_q;
        data_d           = data_q;
        bus_error_d      = bus_error_q;
        wait_cnt_d       = wait_cnt_q;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        mem_address      = '0;
        mem_writedata    = '0;
        cpu_clock_enable = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_read     = 1'b1;
                mem_address  = ADDR_W'(cpu_instr_address);
                accept_state = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                instr_d = mem_readdata;
                state_d = S_DATA;
            end
            S_DATA: begin
                // A simultaneous load+store is illegal; it is flagged and carried out as the store.
                if (cpu_data_write) begin
                    mem_write     = 1'b1;
                    mem_address   = ADDR_W'(cpu_data_address);
                    mem_writedata = cpu_data_writedata;
                    accept_state  = S_EXEC;
                    if (cpu_data_read) begin
                        bus_error_d = 1'b1;
                    end
                end else if (cpu_data_read) begin
                    mem_read     = 1'b1;
                    mem_address  = ADDR_W'(cpu_data_address);
                    accept_state = S_DATA_WAIT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_DATA_WAIT: begin
                data_d  = mem_readdata;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                cpu_clock_enable = 1'b1;
                state_d          = cpu_active ? S_FETCH : S_HALTED;
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_HALTED;
            end
        endcase

        if (mem_read || mem_write) begin
            if (!mem_waitrequest) begin
                state_d = accept_state;
            end else if (wait_inc >= CNT_LIMIT) begin
                bus_error_d = 1'b1;
                state_d     = S_HALTED;
            end else begin
                wait_cnt_d = wait_inc;
            end
        end

        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            instr_q     <= '0;
            data_q      <= '0;
            bus_error_q <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            data_q      <= data_d;
            bus_error_q <= bus_error_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign cpu_instr_readdata = instr_q;
    assign cpu_data_readdata  = data_q;
    assign bus_error          = bus_error_q;
    assign dbg_state          = state_q;

`ifdef HARVARD_SEQ_PERF_EN
    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic [31:0] perf_retired_q, perf_retired_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Stall cycles are those where a request is presented and the memory holds it off.
    always_comb begin
        perf_cycles_d  = perf_cycles_q;
        perf_retired_d = perf_retired_q;
        perf_stall_d   = perf_stall_q;
        if (state_q != S_IDLE && state_q != S_HALTED) begin
            perf_cycles_d = perf_cycles_q + 32'd1;
        end
        if (state_q == S_EXEC) begin
            perf_retired_d = perf_retired_q + 32'd1;
        end
        if ((mem_read || mem_write) && mem_waitrequest) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cycles_q  <= '0;
            perf_retired_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_cycles_q  <= perf_cycles_d;
            perf_retired_q <= perf_retired_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_cycles  = perf_cycles_q;
    assign perf_retired = perf_retired_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_harvard_mem_sequencer.sv
// Self-checking bench for harvard_mem_sequencer: directed scenarios plus a randomized program
// checked against a transaction-level memory/CPU reference model.
module tb_harvard_mem_sequencer;

    localparam int          WAIT_LIMIT   = 8;
    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_instr_address;
    logic [31:0] cpu_instr_readdata;
    logic [31:0] cpu_data_address;
    logic        cpu_data_read;
    logic        cpu_data_write;
    logic [31:0] cpu_data_writedata;
    logic [31:0] cpu_data_readdata;
    logic        cpu_active;
    logic        cpu_clock_enable;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic        bus_error;
    logic [2:0]  dbg_state;
`ifdef HARVARD_SEQ_PERF_EN
    logic [31:0] perf_cycles;
    logic [31:0] perf_retired;
    logic [31:0] perf_stall;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] dev_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic        rd_pending;
    logic [31:0] rd_val;
    logic        acc_rd;
    logic        acc_wr;
    logic [65:0] exp_q [$];

    always #5 clk = ~clk;

    harvard_mem_sequencer #(
        .WAIT_LIMIT(WAIT_LIMIT),
        .ADDR_W    (32)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .cpu_instr_address (cpu_instr_address),
        .cpu_instr_readdata(cpu_instr_readdata),
        .cpu_data_address  (cpu_data_address),
        .cpu_data_read     (cpu_data_read),
        .cpu_data_write    (cpu_data_write),
        .cpu_data_writedata(cpu_data_writedata),
        .cpu_data_readdata (cpu_data_readdata),
        .cpu_active        (cpu_active),
        .cpu_clock_enable  (cpu_clock_enable),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_writedata     (mem_writedata),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .bus_error         (bus_error),
        .dbg_state         (dbg_state)
`ifdef HARVARD_SEQ_PERF_EN
        ,
        .perf_cycles       (perf_cycles),
        .perf_retired      (perf_retired),
        .perf_stall        (perf_stall)
`endif
    );

    function automatic logic [31:0] dev_rd(input logic [31:0] a);
        if (dev_mem.exists(a)) return dev_mem[a];
        return 32'h0;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return 32'h0;
    endfunction

    task automatic set_cpu(input logic [31:0] pc, input logic rd, input logic wr,
                           input logic [31:0] da, input logic [31:0] wd, input logic act);
        cpu_instr_address  = pc;
        cpu_data_read      = rd;
        cpu_data_write     = wr;
        cpu_data_address   = da;
        cpu_data_writedata = wd;
        cpu_active         = act;
    endtask

    task automatic apply_reset();
        reset           = 1'b0;
        mem_waitrequest = 1'b0;
        rd_pending      = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // One memory-device clock: readdata is valid only the cycle after an accepted read.
    task automatic cycle(input logic wait_req);
        @(negedge clk);
        mem_readdata    = rd_pending ? rd_val : $urandom;
        rd_pending      = 1'b0;
        mem_waitrequest = wait_req;
        #1;
        acc_rd = mem_read && !mem_waitrequest;
        acc_wr = mem_write && !mem_waitrequest;
        if (acc_rd) begin
            rd_pending = 1'b1;
            rd_val     = dev_rd(mem_address);
        end
        if (acc_wr) dev_mem[mem_address] = mem_writedata;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_cpu(RESET_VECTOR, 1'b1, 1'b1, 32'h1000, 32'hFFFF_FFFF, 1'b1);
        mem_waitrequest = 1'b0;
        mem_readdata    = 32'hA5A5_A5A5;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (cpu_instr_readdata !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0", cpu_instr_readdata); end
        n_checks++; if (cpu_data_readdata !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", cpu_data_readdata); end
        n_checks++; if (cpu_clock_enable !== 1'b0) begin n_fail++; $display("FAIL reset_ce got %b want 0", cpu_clock_enable); end
        n_checks++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read got %b want 0", mem_read); end
        n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_mem_write got %b want 0", mem_write); end
        n_checks++; if (mem_address !== 32'h0) begin n_fail++; $display("FAIL reset_mem_address got %h want 0", mem_address); end
        n_checks++; if (mem_writedata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_writedata got %h want 0", mem_writedata); end
        n_checks++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL reset_bus_error got %b want 0", bus_error); end
    endtask

    task automatic test_first_fetch();
        dev_mem[RESET_VECTOR] = 32'h2402_0005;
        apply_reset();
        set_cpu(RESET_VECTOR, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        cycle(1'b0);
        n_checks++; if ({mem_read, mem_write, mem_address} !== {1'b1, 1'b0, RESET_VECTOR}) begin n_fail++; $display("FAIL fetch_c1_request got %b%b %h want 10 %h", mem_read, mem_write, mem_address, RESET_VECTOR); end
        cycle(1'b0);
        n_checks++; if (cpu_instr_readdata !== 32'h0) begin n_fail++; $display("FAIL fetch_c2_instr_early got %h want 0", cpu_instr_readdata); end
        cycle(1'b0);
        n_checks++; if (cpu_instr_readdata !== 32'h2402_0005) begin n_fail++; $display("FAIL fetch_c3_instr got %h want 24020005", cpu_instr_readdata); end
        n_checks++; if ({cpu_clock_enable, mem_read, mem_write} !== 3'b000) begin n_fail++; $display("FAIL fetch_c3_idle_bus got %b want 000", {cpu_clock_enable, mem_read, mem_write}); end
        cycle(1'b0);
        n_checks++; if (cpu_clock_enable !== 1'b1) begin n_fail++; $display("FAIL fetch_c4_ce got %b want 1", cpu_clock_enable); end
        cpu_instr_address = RESET_VECTOR + 32'd4;
        cycle(1'b0);
        n_checks++; if ({cpu_clock_enable, mem_read, mem_address} !== {1'b0, 1'b1, RESET_VECTOR + 32'd4}) begin n_fail++; $display("FAIL fetch_c5_next got ce=%b rd=%b %h want ce=0 rd=1 %h", cpu_clock_enable, mem_read, mem_address, RESET_VECTOR + 32'd4); end
    endtask

    task automatic test_load();
        dev_mem[RESET_VECTOR] = 32'h8C02_1000;
        dev_mem[32'h1000]     = 32'hDEAD_BEEF;
        apply_reset();
        set_cpu(RESET_VECTOR, 1'b1, 1'b0, 32'h1000, 32'h0, 1'b1);
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b0);
        n_checks++; if ({mem_read, mem_write, mem_address} !== {2'b10, 32'h1000}) begin n_fail++; $display("FAIL load_request got %b%b %h want 10 00001000", mem_read, mem_write, mem_address); end
        cycle(1'b0);
        n_checks++; if ({cpu_clock_enable, mem_read, mem_write, cpu_data_readdata} !== 35'h0) begin n_fail++; $display("FAIL load_wait_phase got ce=%b rd=%b wr=%b data=%h want all 0", cpu_clock_enable, mem_read, mem_write, cpu_data_readdata); end
        cycle(1'b0);
        n_checks++; if ({cpu_clock_enable, cpu_data_readdata} !== {1'b1, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL load_exec got ce=%b data=%h want ce=1 deadbeef", cpu_clock_enable, cpu_data_readdata); end
        cpu_instr_address = RESET_VECTOR + 32'd4;
        cpu_data_read     = 1'b0;
        cycle(1'b0);
        n_checks++; if ({mem_read, mem_address} !== {1'b1, RESET_VECTOR + 32'd4}) begin n_fail++; $display("FAIL load_next_fetch got rd=%b %h want rd=1 %h", mem_read, mem_address, RESET_VECTOR + 32'd4); end
        n_checks++; if (cpu_data_readdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_data_kept got %h want deadbeef", cpu_data_readdata); end
    endtask

    task automatic test_store_wait();
        int writes;
        dev_mem[RESET_VECTOR] = 32'hAC02_2000;
        dev_mem[32'h2000]     = 32'h0;
        apply_reset();
        set_cpu(RESET_VECTOR, 1'b0, 1'b1, 32'h2000, 32'h1234_5678, 1'b1);
        cycle(1'b0);
        cycle(1'b0);
        writes = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(i < 3);
            n_checks++; if ({mem_write, mem_read, mem_address, mem_writedata, cpu_clock_enable} !== {2'b10, 32'h2000, 32'h1234_5678, 1'b0}) begin n_fail++; $display("FAIL store_hold_%0d got wr=%b rd=%b %h %h ce=%b want 1 0 00002000 12345678 0", i, mem_write, mem_read, mem_address, mem_writedata, cpu_clock_enable); end
            if (acc_wr) writes++;
        end
        n_checks++; if (writes !== 1) begin n_fail++; $display("FAIL store_accept_count got %0d want 1", writes); end
        n_checks++; if (dev_rd(32'h2000) !== 32'h1234_5678) begin n_fail++; $display("FAIL store_mem got %h want 12345678", dev_rd(32'h2000)); end
        cycle(1'b0);
        n_checks++; if ({cpu_clock_enable, mem_write} !== 2'b10) begin n_fail++; $display("FAIL store_exec got ce=%b wr=%b want ce=1 wr=0", cpu_clock_enable, mem_write); end
    endtask

    task automatic test_reset_mid_store();
        dev_mem[RESET_VECTOR] = 32'hAC03_3000;
        dev_mem[32'h3000]     = 32'h0000_0055;
        apply_reset();
        set_cpu(RESET_VECTOR, 1'b0, 1'b1, 32'h3000, 32'hCAFE_F00D, 1'b1);
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b1);
        n_checks++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL midreset_store_pending got %b want 1", mem_write); end
        #1 reset = 1'b0;
        #1;
        n_checks++; if ({cpu_clock_enable, mem_read, mem_write, mem_address, mem_writedata, cpu_instr_readdata, cpu_data_readdata, bus_error} !== 0) begin n_fail++; $display("FAIL midreset_outputs got ce=%b rd=%b wr=%b %h %h %h %h err=%b want all 0", cpu_clock_enable, mem_read, mem_write, mem_address, mem_writedata, cpu_instr_readdata, cpu_data_readdata, bus_error); end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0);
            n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL midreset_no_write_%0d got %b want 0", i, mem_write); end
        end
        n_checks++; if (dev_rd(32'h3000) !== 32'h0000_0055) begin n_fail++; $display("FAIL midreset_mem got %h want 00000055", dev_rd(32'h3000)); end
        set_cpu(RESET_VECTOR, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        rd_pending = 1'b0;
        reset      = 1'b1;
        cycle(1'b0);
        n_checks++; if ({mem_read, mem_address} !== {1'b1, RESET_VECTOR}) begin n_fail++; $display("FAIL midreset_restart got rd=%b %h want rd=1 %h", mem_read, mem_address, RESET_VECTOR); end
    endtask

    task automatic test_timeout();
        apply_reset();
        set_cpu(RESET_VECTOR, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < WAIT_LIMIT; i++) begin
            cycle(1'b1);
            n_checks++; if ({mem_read, bus_error, cpu_clock_enable} !== 3'b100) begin n_fail++; $display("FAIL timeout_waiting_%0d got rd=%b err=%b ce=%b want 1 0 0", i, mem_read, bus_error, cpu_clock_enable); end
        end
        cycle(1'b1);
        n_checks++; if ({bus_error, mem_read} !== 2'b10) begin n_fail++; $display("FAIL timeout_trip got err=%b rd=%b want err=1 rd=0", bus_error, mem_read); end
        for (int i = 0; i < 10; i++) begin
            cycle(1'($urandom_range(0, 1)));
            n_checks++; if ({bus_error, mem_read, mem_write, cpu_clock_enable} !== 4'b1000) begin n_fail++; $display("FAIL timeout_halted_%0d got err=%b rd=%b wr=%b ce=%b want 1 0 0 0", i, bus_error, mem_read, mem_write, cpu_clock_enable); end
        end
    endtask

    task automatic test_halt();
        dev_mem[RESET_VECTOR] = 32'h03E0_0008;
        apply_reset();
        set_cpu(RESET_VECTOR, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (3) cycle(1'b0);
        cycle(1'b0);
        n_checks++; if (cpu_clock_enable !== 1'b1) begin n_fail++; $display("FAIL halt_exec_ce got %b want 1", cpu_clock_enable); end
        for (int i = 0; i < 20; i++) begin
            cycle(1'($urandom_range(0, 1)));
            n_checks++; if ({mem_read, mem_write, cpu_clock_enable, bus_error} !== 4'b0000) begin n_fail++; $display("FAIL halt_quiet_%0d got rd=%b wr=%b ce=%b err=%b want 0 0 0 0", i, mem_read, mem_write, cpu_clock_enable, bus_error); end
        end
`ifdef HARVARD_SEQ_PERF_EN
        n_checks++; if (perf_retired !== 32'd1) begin n_fail++; $display("FAIL halt_perf_retired got %0d want 1", perf_retired); end
        n_checks++; if (perf_cycles !== 32'd4) begin n_fail++; $display("FAIL halt_perf_cycles got %0d want 4", perf_cycles); end
`endif
    endtask

    task automatic test_random(input int n_instr);
        logic [31:0] pc, iw, da, wd, last_load;
        logic        rd, wr, err_exp, w, done, prev_hold;
        logic [65:0] cur, prev, obs, exp_t;
        int          op, consec, cyc_cnt, stalls, lat_exp;
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            wd = $urandom;
            dev_mem[32'h1000 + 32'(4 * k)] = wd;
            ref_mem[32'h1000 + 32'(4 * k)] = wd;
        end
        pc        = RESET_VECTOR;
        last_load = 32'h0;
        err_exp   = 1'b0;
        consec    = 0;
        for (int i = 0; i < n_instr; i++) begin
            iw = $urandom;
            dev_mem[pc] = iw;
            ref_mem[pc] = iw;
            op = $urandom_range(0, 9);
            rd = (op >= 3 && op <= 5) || (op == 9);
            wr = (op >= 6);
            da = 32'h1000 + 32'(4 * $urandom_range(0, 7));
            wd = $urandom;
            set_cpu(pc, rd, wr, da, wd, 1'b1);
            exp_q.push_back({2'b10, pc, 32'h0});
            if (wr) begin
                exp_q.push_back({2'b01, da, wd});
                ref_mem[da] = wd;
                if (rd) err_exp = 1'b1;
            end else if (rd) begin
                exp_q.push_back({2'b10, da, 32'h0});
                last_load = ref_rd(da);
            end
            cyc_cnt   = 0;
            stalls    = 0;
            done      = 1'b0;
            prev_hold = 1'b0;
            prev      = '0;
            while (!done && cyc_cnt < 100) begin
                w      = (consec < 3) && ($urandom_range(0, 3) == 0);
                consec = w ? consec + 1 : 0;
                cycle(w);
                cyc_cnt++;
                cur = {mem_read, mem_write, mem_address, mem_writedata};
                n_checks++; if (mem_read && mem_write) begin n_fail++; $display("FAIL rand_both_strobes instr %0d got rd=1 wr=1 want exclusive", i); end
                if (prev_hold) begin
                    n_checks++; if (cur !== prev) begin n_fail++; $display("FAIL rand_hold instr %0d got %h want %h", i, cur, prev); end
                end
                prev      = cur;
                prev_hold = (mem_read || mem_write) && w;
                if ((mem_read || mem_write) && w) stalls++;
                if (acc_rd || acc_wr) begin
                    obs = {acc_rd, acc_wr, mem_address, acc_wr ? mem_writedata : 32'h0};
                    if (exp_q.size() == 0) begin
                        n_checks++; n_fail++; $display("FAIL rand_extra_access instr %0d got %h want none", i, obs);
                    end else begin
                        exp_t = exp_q.pop_front();
                        n_checks++; if (obs !== exp_t) begin n_fail++; $display("FAIL rand_access instr %0d got %h want %h", i, obs, exp_t); end
                    end
                end
                if (cpu_clock_enable) begin
                    done    = 1'b1;
                    lat_exp = 4 + ((rd && !wr) ? 1 : 0) + stalls;
                    n_checks++; if (cyc_cnt !== lat_exp) begin n_fail++; $display("FAIL rand_latency instr %0d got %0d want %0d", i, cyc_cnt, lat_exp); end
                    n_checks++; if (cpu_instr_readdata !== ref_rd(pc)) begin n_fail++; $display("FAIL rand_instr instr %0d got %h want %h", i, cpu_instr_readdata, ref_rd(pc)); end
                    n_checks++; if (cpu_data_readdata !== last_load) begin n_fail++; $display("FAIL rand_load_data instr %0d got %h want %h", i, cpu_data_readdata, last_load); end
                    n_checks++; if (bus_error !== err_exp) begin n_fail++; $display("FAIL rand_bus_error instr %0d got %b want %b", i, bus_error, err_exp); end
                    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL rand_missing_access instr %0d got %0d left want 0", i, exp_q.size()); end
                    exp_q.delete();
                end
            end
            if (!done) begin
                n_checks++; n_fail++;
                $display("FAIL rand_timeout instr %0d got no clock_enable in %0d cycles want one", i, cyc_cnt);
            end
            pc = pc + 32'd4;
        end
        for (int k = 0; k < 8; k++) begin
            da = 32'h1000 + 32'(4 * k);
            n_checks++; if (dev_rd(da) !== ref_rd(da)) begin n_fail++; $display("FAIL rand_final_mem %h got %h want %h", da, dev_rd(da), ref_rd(da)); end
        end
    endtask

    initial begin
        reset           = 1'b0;
        mem_waitrequest = 1'b0;
        mem_readdata    = 32'h0;
        rd_pending      = 1'b0;
        rd_val          = 32'h0;
        acc_rd          = 1'b0;
        acc_wr          = 1'b0;
        set_cpu(32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        test_reset();
        test_first_fetch();
        test_load();
        test_store_wait();
        test_reset_mid_store();
        test_timeout();
        test_halt();
        test_random(40);
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got no end of run want finish before 40000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
